// File: rtl/bcd_stopwatch.sv
// BCD stopwatch/timer core: cascaded fraction/second/minute digits, start/stop FSM, lap hold,
// preset alarm. Define BCD_STOPWATCH_COUNTDOWN_EN to add the countdown mode.
module bcd_stopwatch #(
  parameter int unsigned FRAC_DIGITS = 2,
  parameter int unsigned MIN_DIGITS  = 2,
  localparam int unsigned NDIG       = FRAC_DIGITS + 2 + MIN_DIGITS
) (
  input  logic            clk_100mhz,
  input  logic            rst,
  input  logic            tick,
  input  logic            start,
  input  logic            stop,
  input  logic            lap,
  input  logic            clear,
  input  logic            load,
  input  logic            down,
  input  logic [4*NDIG-1:0] preset_bcd,
  output logic [4*NDIG-1:0] disp_bcd,
  output logic            time_out,
  output logic            running,
  output logic            lap_active,
  output logic            ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StStop, StDone} state_e;

  state_e              state_q, state_d;
  logic [4*NDIG-1:0]   count_q, count_d;
  logic [4*NDIG-1:0]   disp_q, disp_d;
  logic [4*NDIG-1:0]   preset_q, preset_d;
  logic                time_out_q, time_out_d;
  logic                ovf_q, ovf_d;
  logic                lap_q, lap_d;
  logic                mode_down;
  logic                start_ok;
  logic [4*NDIG-1:0]   clamped, inc_val;
  logic                all_max;

  // Seconds-tens is the only base-6 digit.
  function automatic logic [3:0] dmax(input int unsigned i);
    return (i == FRAC_DIGITS + 1) ? 4'd5 : 4'd9;
  endfunction

  always_comb begin
    logic       carry;
    logic [3:0] nib;
    clamped = '0;
    inc_val = '0;
    carry   = 1'b1;
    nib     = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      nib = preset_bcd[4*i +: 4];
      clamped[4*i +: 4] = (nib > dmax(i)) ? dmax(i) : nib;
      nib = count_q[4*i +: 4];
      if (carry && nib >= dmax(i)) begin
        inc_val[4*i +: 4] = 4'd0;
      end else if (carry) begin
        inc_val[4*i +: 4] = nib + 4'd1;
        carry = 1'b0;
      end else begin
        inc_val[4*i +: 4] = nib;
      end
    end
    // Carry out of the top digit means every digit is at its maximum.
    all_max = carry;
  end

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
  logic              mode_q, mode_d;
  logic [4*NDIG-1:0] dec_val;

  always_comb begin
    logic       borrow;
    logic [3:0] nib;
    dec_val = '0;
    borrow  = 1'b1;
    nib     = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      nib = count_q[4*i +: 4];
      if (borrow && nib == 4'd0) begin
        dec_val[4*i +: 4] = dmax(i);
      end else if (borrow) begin
        dec_val[4*i +: 4] = nib - 4'd1;
        borrow = 1'b0;
      end else begin
        dec_val[4*i +: 4] = nib;
      end
    end
  end

  assign mode_down = mode_q;
  assign start_ok  = !(down && count_q == '0);
`else
  logic unused_down;
  assign unused_down = down;
  assign mode_down   = 1'b0;
  assign start_ok    = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    preset_d   = preset_q;
    time_out_d = time_out_q;
    ovf_d      = ovf_q;
    lap_d      = lap_q;
    disp_d     = lap_q ? disp_q : count_q;
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
    mode_d     = mode_q;
`endif

    if (!mode_down && preset_q != '0 && count_q == preset_q) time_out_d = 1'b1;

    if (state_q == StRun && tick && !clear && !stop) begin
      if (!mode_down) begin
        if (all_max) begin
          ovf_d   = 1'b1;
          state_d = StDone;
        end else begin
          count_d = inc_val;
        end
      end
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
      else begin
        if (count_q != '0) count_d = dec_val;
        if (count_q == '0 || dec_val == '0) begin
          time_out_d = 1'b1;
          state_d    = StDone;
        end
      end
`endif
    end

    if (clear) begin
      count_d    = '0;
      disp_d     = '0;
      time_out_d = 1'b0;
      ovf_d      = 1'b0;
      lap_d      = 1'b0;
      state_d    = StIdle;
    end else if (load && state_q != StRun) begin
      preset_d   = clamped;
      time_out_d = 1'b0;
      ovf_d      = 1'b0;
      state_d    = StIdle;
      if (mode_down) count_d = clamped;
    end else if (stop) begin
      if (state_q == StRun) state_d = StStop;
    end else if (start) begin
      if ((state_q == StIdle || state_q == StStop) && start_ok) begin
        state_d = StRun;
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
        mode_d  = down;
`endif
      end
    end else if (lap) begin
      lap_d = (state_q == StRun) ? !lap_q : 1'b0;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      disp_q     <= '0;
      preset_q   <= '0;
      time_out_q <= 1'b0;
      ovf_q      <= 1'b0;
      lap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
      preset_q   <= preset_d;
      time_out_q <= time_out_d;
      ovf_q      <= ovf_d;
      lap_q      <= lap_d;
    end
  end

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
  always_ff @(posedge clk_100mhz) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end
`endif

  assign disp_bcd   = disp_q;
  assign time_out   = time_out_q;
  assign running    = (state_q == StRun);
  assign lap_active = lap_q;
  assign ovf        = ovf_q;

endmodule
